// File: rtl/mat_pkg.sv
// mat_pkg: shared FSM encoding and default sizing for the matrix stream host.
package mat_pkg;
    localparam int DEF_DIM_LOG    = 1;
    localparam int DEF_DATA_WIDTH = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RECV, ST_DONE} state_t;
endpackage

// File: rtl/mat_sdp_ram.sv
// mat_sdp_ram: simple dual-port RAM, one write port and one registered read port.
module mat_sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/mat_stream_host.sv
// mat_stream_host: streams operands A,B to an accelerator and collects the result matrix.
// Optional receive watchdog enabled by defining MAT_HOST_TIMEOUT_EN.
module mat_stream_host
    import mat_pkg::*;
#(
    parameter int DIM_LOG        = DEF_DIM_LOG,
    parameter int DIM            = 2**DIM_LOG,
    parameter int SIZE           = DIM*DIM,
    parameter int SIZE_LOG       = 2*DIM_LOG,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
)(
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    input  logic                  ld_en,
    input  logic [SIZE_LOG:0]     ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  start,
    output logic                  m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast,
    input  logic                  m00_axis_tready,
    input  logic                  s00_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                  s00_axis_tlast,
    output logic                  s00_axis_tready,
    input  logic [SIZE_LOG-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int OA = SIZE_LOG + 1;
    state_t                r_state, w_nstate;
    logic [OA-1:0]         r_sidx, w_op_raddr;
    logic [SIZE_LOG-1:0]   r_ridx;
    logic                  r_err, r_rd_vld;
    logic [DATA_WIDTH-1:0] w_op_q, w_res_q;
    logic                  w_ld_we, w_m_hs, w_s_hs, w_last_o, w_last_r, w_tmo;

    assign w_m_hs   = r_state == ST_SEND && m00_axis_tready;
    assign w_s_hs   = r_state == ST_RECV && s00_axis_tvalid;
    assign w_last_o = r_sidx == OA'(2*SIZE-1);
    assign w_last_r = r_ridx == SIZE_LOG'(SIZE-1);
    assign w_ld_we  = ld_en && !busy && {1'b0, ld_addr} < (OA+1)'(2*SIZE);
    // Read one word ahead so tdata is the RAM output register and stays put while stalled.
    assign w_op_raddr = w_m_hs ? r_sidx + 1'b1 : (r_state == ST_SEND ? r_sidx : '0);

`ifdef MAT_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd;
    assign w_tmo = r_state == ST_RECV && !w_s_hs && r_wd == WD_W'(TIMEOUT_CYCLES-1);
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) r_wd <= '0;
        else r_wd <= (r_state == ST_RECV && !w_s_hs) ? r_wd + 1'b1 : '0;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            ST_IDLE: w_nstate = start ? ST_SEND : ST_IDLE;
            ST_SEND: w_nstate = (w_m_hs && w_last_o) ? ST_RECV : ST_SEND;
            ST_RECV: w_nstate = ((w_s_hs && w_last_r) || w_tmo) ? ST_DONE : ST_RECV;
            default: w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state  <= ST_IDLE;
            r_sidx   <= '0;
            r_ridx   <= '0;
            r_err    <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_sidx   <= w_op_raddr;
            r_ridx   <= w_s_hs ? r_ridx + 1'b1 : (r_state == ST_RECV ? r_ridx : '0);
            r_err    <= (r_state == ST_IDLE && start) ? 1'b0
                      : r_err | w_tmo | (w_s_hs && (s00_axis_tlast != w_last_r));
            r_rd_vld <= 1'b1;
        end
    end

    assign m00_axis_tvalid = r_state == ST_SEND;
    assign m00_axis_tdata  = w_op_q;
    assign m00_axis_tlast  = m00_axis_tvalid && w_last_o;
    assign s00_axis_tready = r_state == ST_RECV;
    assign busy            = r_state != ST_IDLE;
    assign done            = r_state == ST_DONE;
    assign err             = r_err;
    // Result RAM output is not reset, so mask it until the first post-reset read lands.
    assign rd_data         = r_rd_vld ? w_res_q : '0;

    mat_sdp_ram #(.WIDTH(DATA_WIDTH), .DEPTH(2*SIZE), .AW(OA)) u_op (
        .i_clk(s00_axi_aclk), .i_we(w_ld_we), .i_waddr(ld_addr), .i_wdata(ld_data),
        .i_raddr(w_op_raddr), .o_rdata(w_op_q)
    );

    mat_sdp_ram #(.WIDTH(DATA_WIDTH), .DEPTH(SIZE), .AW(SIZE_LOG)) u_res (
        .i_clk(s00_axi_aclk), .i_we(w_s_hs), .i_waddr(r_ridx), .i_wdata(s00_axis_tdata),
        .i_raddr(rd_addr), .o_rdata(w_res_q)
    );
endmodule

// File: tb/tb_mat_stream_host.sv
// tb_mat_stream_host: directed bench with a stream/result model for mat_stream_host (DIM_LOG=1).
module tb_mat_stream_host;
    localparam int DW = 32, SZ = 4, SL = 2, TMO = 16;
    logic          clk = 1'b0, rst_n = 1'b0;
    logic          ld_en = 1'b0, start = 1'b0;
    logic [SL:0]   ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          m_tvalid, m_tlast, m_tready = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic [SL-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy, done, err;
    int vecs = 0, errs = 0;
    int op[8], prod[4], alt[4];
    int k = 0, hs_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    mat_stream_host #(.DIM_LOG(1), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .start(start),
        .m00_axis_tvalid(m_tvalid), .m00_axis_tdata(m_tdata), .m00_axis_tlast(m_tlast),
        .m00_axis_tready(m_tready),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
        .s00_axis_tready(s_tready),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: the stream must present op[] in order, tlast only on the eighth word.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (m_tvalid) begin
            if (k < 8) begin
                chk("tdata", m_tdata, op[k]);
                chk("tlast", m_tlast, k == 7);
            end else chk("overrun", k, 7);
            if (m_tready) begin k++; hs_cnt++; end
        end
    end

    task automatic load();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            ld_en = 1'b1; ld_addr = 3'(i); ld_data = op[i];
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic go();
        @(posedge clk); #1;
        start = 1'b1; k = 0; hs_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_clear", err, 0);
        chk("busy_send", busy, 1);
    endtask

    task automatic send(input bit tog, input int exp_vc);
        int vc = 0;
        m_tready = 1'b1;
        for (int c = 0; c < 200 && hs_cnt < 8; c++) begin
            @(negedge clk);
            if (m_tvalid) vc++;
            @(posedge clk); #1;
            if (tog) m_tready = !m_tready;
        end
        m_tready = 1'b0;
        chk("handshakes", hs_cnt, 8);
        chk("valid_cycles", vc, exp_vc);
        chk("tvalid_off", m_tvalid, 0);
        chk("s_tready_on", s_tready, 1);
    endtask

    task automatic recv(input int w[4], input bit [3:0] tl, input bit exp_err);
        int d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            int t = 0;
            s_tvalid = 1'b1; s_tdata = w[i]; s_tlast = tl[i];
            @(negedge clk);
            while (!s_tready && t < 50) begin @(negedge clk); t++; end
            if (t == 50) chk("recv_wait", t, 0);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("done_pulse", done, 1);
        chk("s_tready_drop", s_tready, 0);
        chk("err_done", err, exp_err);
        @(posedge clk); #1;
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
        chk("err_sticky", err, exp_err);
        chk("done_once", done_cnt - d0, 1);
    endtask

    task automatic readback(input int w[4]);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            @(posedge clk); #1;
            chk("rd_data", rd_data, w[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) op[i] = i + 1;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                prod[i*2+j] = op[i*2] * op[4+j] + op[i*2+1] * op[6+j];
        for (int i = 0; i < 4; i++) alt[i] = 10 * (i + 1);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data", rd_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        load();

        // Full-rate send, good results; load and start during RECV must be ignored.
        go();
        send(1'b0, 8);
        ld_en = 1'b1; ld_addr = '0; ld_data = 99; start = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0; start = 1'b0;
        chk("recv_hold", s_tready, 1);
        recv(prod, 4'b1000, 1'b0);
        readback(prod);
        rd_addr = 2'd0; @(posedge clk); #1;
        chk("rd_lit0", rd_data, 19);
        rd_addr = 2'd3; @(posedge clk); #1;
        chk("rd_lit3", rd_data, 50);

        // Stalling send, then early tlast on beat 2.
        go();
        send(1'b1, 15);
        recv(alt, 4'b0100, 1'b1);
        readback(alt);

        // Reset mid-SEND after three handshakes, then resend from word 0.
        go();
        chk("err_cleared", err, 0);
        m_tready = 1'b1;
        for (int c = 0; c < 50 && hs_cnt < 3; c++) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0; m_tready = 1'b0;
        #1;
        chk("mid_rst_tvalid", m_tvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_s_tready", s_tready, 0);
        k = 0; hs_cnt = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        go();
        chk("resend_word0", m_tdata, 1);
        send(1'b0, 8);
        recv(prod, 4'b1000, 1'b0);

`ifdef MAT_HOST_TIMEOUT_EN
        begin
            int n = 0;
            go();
            send(1'b0, 8);
            while (!done && n < 100) begin @(posedge clk); #1; n++; end
            chk("tmo_cycles", n, TMO);
            chk("tmo_err", err, 1);
            chk("tmo_s_tready", s_tready, 0);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mat_stream_host.md
MAT_STREAM_HOST -- requirements
Module: mat_stream_host

Interface
REQ-001 SHALL have parameter DIM_LOG, default 1: log2 of the matrix dimension.
REQ-002 SHALL have parameter DIM, default 2**DIM_LOG: the matrix dimension.
REQ-003 SHALL have parameter SIZE, default DIM*DIM: words per matrix.
REQ-004 SHALL have parameter SIZE_LOG, default 2*DIM_LOG: result address width.
REQ-005 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1024: receive watchdog limit.
REQ-007 SHALL have port s00_axi_aclk, input, 1: the single clock. All logic is on its rising edge.
REQ-008 SHALL have port s00_axi_aresetn, input, 1: reset. It is asynchronous and active-low.
REQ-009 SHALL have port ld_en, input, 1: operand buffer write strobe.
REQ-010 SHALL have port ld_addr, input, SIZE_LOG+1: operand address. A occupies 0..SIZE-1; B occupies SIZE..2*SIZE-1.
REQ-011 SHALL have port ld_data, input, DATA_WIDTH: operand write data.
REQ-012 SHALL have port start, input, 1: begin transaction; one-cycle pulse.
REQ-013 SHALL have ports m00_axis_tvalid (output, 1), m00_axis_tdata (output, DATA_WIDTH), m00_axis_tlast (output, 1) and m00_axis_tready (input, 1): the operand stream toward the accelerator.
REQ-014 SHALL have ports s00_axis_tvalid (input, 1), s00_axis_tdata (input, DATA_WIDTH), s00_axis_tlast (input, 1) and s00_axis_tready (output, 1): the result stream from the accelerator.
REQ-015 SHALL have port rd_addr, input, SIZE_LOG: result buffer read address.
REQ-016 SHALL have port rd_data, output, DATA_WIDTH: registered result word, valid one cycle after rd_addr.
REQ-017 SHALL have ports busy (output, 1), done (output, 1) and err (output, 1): status.

Function
REQ-018 SHALL implement the FSM states IDLE, SEND, RECV and DONE.
REQ-019 SHALL transition IDLE->SEND when start=1. The next cycle SHALL drive m00_axis_tvalid=1 with tdata = word 0.
REQ-020 SHALL, in SEND, advance the word index only on tvalid&&tready, and hold tdata and tlast stable while tready=0.
REQ-021 SHALL assert m00_axis_tlast only with word 2*SIZE-1.
REQ-022 SHALL, after the last SEND handshake, deassert m00_axis_tvalid in the next cycle, enter RECV and set s00_axis_tready=1.
REQ-023 SHALL, in RECV, store each accepted beat at result index 0..SIZE-1 in arrival order.
REQ-024 SHALL set sticky err if s00_axis_tlast=1 on a beat other than SIZE-1, or if it is 0 on beat SIZE-1. Reception SHALL continue to SIZE beats regardless.
REQ-025 SHALL, after beat SIZE-1, drop s00_axis_tready, enter DONE, pulse done for exactly one cycle, then return to IDLE.
REQ-026 SHALL hold busy=1 in the states SEND, RECV and DONE.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL ignore ld_en while busy, and ignore ld_addr >= 2*SIZE.
REQ-029 SHALL clear err on an accepted start.
REQ-030 SHALL stream a back-to-back transaction identically, provided start arrives at least one cycle after done.

Reset
REQ-031 SHALL, on reset assertion, immediately force the state to IDLE and set m00_axis_tvalid, m00_axis_tlast, s00_axis_tready, busy, done, err, rd_data and all indices to 0. This holds mid-transaction.
REQ-032 SHALL NOT reset operand and result buffer contents; they are RAM-inferable.

Configuration
REQ-033 SHALL, with MAT_HOST_TIMEOUT_EN defined, count cycles in RECV without an accepted beat. On reaching TIMEOUT_CYCLES it SHALL set err, drop s00_axis_tready, pulse done and return to IDLE.
REQ-034 SHALL, without MAT_HOST_TIMEOUT_EN, contain no watchdog logic, and RECV SHALL wait indefinitely.

Structure
REQ-035 SHALL place the FSM state encoding and the default DIM_LOG/DATA_WIDTH constants in the shared package mat_pkg.
REQ-036 SHALL use one sub-module, mat_sdp_ram: a simple dual-port synchronous RAM instantiated for the operand buffer (2*SIZE words) and the result buffer (SIZE words).

Verification
REQ-037 SHALL cover: DIM_LOG=1, load A=1,2,3,4 and B=5,6,7,8, tready held 1, start -> 8 beats on consecutive cycles, tdata 1..8, tlast only on 8.
REQ-038 SHALL cover: same load, tready toggling 1,0,1,0 -> each word held stable while tready=0, 8 handshakes total, no word skipped or duplicated.
REQ-039 SHALL cover: after SEND, drive results 19,22,43,50 with tlast on the 4th beat -> done pulses once, err=0, and rd_addr 0..3 returns 19,22,43,50.
REQ-040 SHALL cover: tlast on result beat 2 -> err=1, 4 beats still stored, done pulses.
REQ-041 SHALL cover: reset asserted after 3 SEND handshakes -> tvalid=0 and busy=0 immediately; a new start resends from word 0 (value 1).
REQ-042 SHALL cover: MAT_HOST_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no result beats -> err=1 and done 16 cycles after entering RECV.
